dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
// Shares the single-port data memory between two requesters: m0 (CPU MEM stage) and
// m1 (debug/DMA loader). Arbitrates, converts {size, addr} into byte enables and
// lane-replicated write data, checks alignment, and sign-extends read data.
// Sits between the requesters and a synchronous RAM with one-cycle read latency.
// PARAMETERS
// ADDR_W   14  byte-address width; RAM word index is ADDR_W-2 bits
// FAIR     1   1 = round-robin between m0/m1; 0 = fixed priority, m0 always wins
// PORTS (N = 0,1; one identical set per requester)
// clk        in   1        clock; all state changes on posedge
// rst        in   1        reset, synchronous, active-high
// mN_req     in   1        request; mN_we/size/addr/wdata held stable until mN_ready
// mN_we      in   1        1 = store, 0 = load
// mN_size    in   2        0 word, 1 half, 2 byte, 3 reserved (error)
// mN_addr    in   ADDR_W   byte address
// mN_wdata   in   32       store data, low bits significant for half/byte
// mN_ready   out  1        request accepted this cycle (combinational)
// mN_rvalid  out  1        one-cycle completion pulse (loads and stores)
// mN_rdata   out  32       sign-extended load data, valid with mN_rvalid; 0 for stores/errors
// mN_err     out  1        with mN_rvalid: misaligned or size 3; no RAM access made
// mem_en     out  1        RAM access strobe
// mem_we     out  1        RAM write enable (only with mem_en)
// mem_addr   out  ADDR_W-2 RAM word index = addr[ADDR_W-1:2]
// mem_be     out  4        byte enables
// mem_wdata  out  32       lane-replicated write data
// mem_rdata  in   32       raw RAM word, valid the cycle after mem_en
// BEHAVIOUR
// - States IDLE, ISSUE, RESP, ERR. Reset: IDLE, last_grant = 1 (m0 wins first tie),
//   all outputs 0, request latch cleared.
// - IDLE: mN_ready=1 for the selected requester only, and only in IDLE. If both req:
//   FAIR=1 -> the one not equal to last_grant; FAIR=0 -> m0. Accept latches owner,
//   we, size, addr, wdata; last_grant <= owner. Aligned -> ISSUE, else -> ERR.
// - Alignment: word needs addr[1:0]=0; half needs addr[0]=0; byte always; size 3 error.
// - ISSUE (1 cycle): mem_en=1, mem_we=latched we, mem_addr, mem_be, mem_wdata from
//   latch; -> RESP.
// - mem_be: word 1111; half addr[1]=0 -> 0011, =1 -> 1100; byte 0001<<addr[1:0].
// - mem_wdata: word as-is; half {wdata[15:0],wdata[15:0]}; byte {4{wdata[7:0]}}.
// - RESP (1 cycle): owner rvalid=1, err=0; load rdata = selected lane of mem_rdata,
//   sign-extended (half lane by addr[1], byte lane by addr[1:0]); store rdata=0; -> IDLE.
// - ERR (1 cycle): owner rvalid=1, err=1, rdata=0, mem_en stays 0; -> IDLE.
// - Latency accept->rvalid: 2 cycles (ok), 1 cycle (err). Throughput: one access per
//   3 cycles; no new accept outside IDLE, so a req arriving in ISSUE/RESP waits.
// - Non-owner never sees rvalid/err. mem_en, mem_we, rvalid are 0 outside listed states.
// - rst in any state: transaction dropped, no rvalid issued, state IDLE next cycle;
//   a write latched but not yet in ISSUE is never performed.
// - Requester dropping req before ready is legal; nothing latched.
// TESTING
// - Reset: hold rst 2 cycles -> all outputs 0, state IDLE; after release, both req
//   same cycle -> m0_ready=1, m1_ready=0.
// - m0 word store addr 0x0010 wdata 0xDEADBEEF -> ISSUE mem_addr=4, be=1111; m0 word load
//   0x0010 -> m0_rvalid two cycles after accept, m0_rdata=0xDEADBEEF.
// - m1 half store addr 0x0006 wdata 0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD; half
//   load addr 0x0006 with mem_rdata=0xABCD0000 -> m1_rdata=0xFFFFABCD.
// - Byte load addr 0x0003, mem_rdata=0x80112233 -> rdata=0xFFFFFF80; addr 0x0002 -> 0x00000011.
// - FAIR=1, both req held for 4 transactions -> grants m0,m1,m0,m1; FAIR=0 -> m0 x4.
// - m0 half load addr 0x0001 -> err=1, rvalid 1 cycle after accept, mem_en never 1;
//   rst asserted during ISSUE -> no rvalid, IDLE next cycle, m0_ready=1 on fresh req.

Source files
------------

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_port_arbiter
// Description : Two-requester arbiter in front of a single-port data memory.
//               Converts {size, addr} to byte enables and lane-replicated
//               write data, rejects misaligned accesses without touching the
//               RAM, and returns sign-extended load data one cycle after the
//               RAM access.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter bit FAIR   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    // requester 0 (CPU MEM stage)
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ready,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,
    // requester 1 (debug / DMA loader)
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ready,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,
    // synchronous RAM, one-cycle read latency
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] c_SIZE_WORD = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_BYTE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // Request latch: owner plus the accepted command
    logic                r_owner;
    logic                r_last_grant;
    logic                r_we;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;

    logic                w_grant;
    logic                w_accept;
    logic                w_sel_we;
    logic [1:0]          w_sel_size;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [31:0]         w_sel_wdata;
    logic                w_sel_aligned;

    logic [3:0]          w_be;
    logic [31:0]         w_wdata_rep;
    logic [15:0]         w_half_lane;
    logic [7:0]          w_byte_lane;
    logic [31:0]         w_load_data;

    logic                w_rvalid;
    logic                w_err;
    logic [31:0]         w_rdata;

    // Grant selection: on a tie, round-robin picks the port that did not win
    // last time; fixed priority always picks m0. Last_grant resets to 1 so m0
    // wins the first tie in either mode.
    always_comb begin
        if (m0_req && m1_req) begin
            w_grant = FAIR ? ~r_last_grant : 1'b0;
        end else begin
            w_grant = m1_req;
        end
    end

    // Accept only in IDLE and never while reset is asserted
    assign w_accept    = (r_state == ST_IDLE) && !rst && (m0_req || m1_req);
    assign m0_ready    = w_accept && !w_grant;
    assign m1_ready    = w_accept &&  w_grant;

    assign w_sel_we    = w_grant ? m1_we    : m0_we;
    assign w_sel_size  = w_grant ? m1_size  : m0_size;
    assign w_sel_addr  = w_grant ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_grant ? m1_wdata : m0_wdata;

    // Alignment check of the command being accepted; size 3 is always an error
    always_comb begin
        case (w_sel_size)
            c_SIZE_WORD: w_sel_aligned = (w_sel_addr[1:0] == 2'b00);
            c_SIZE_HALF: w_sel_aligned = !w_sel_addr[0];
            c_SIZE_BYTE: w_sel_aligned = 1'b1;
            default:     w_sel_aligned = 1'b0;
        endcase
    end

    // State register and request latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_size       <= 2'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                r_we         <= w_sel_we;
                r_size       <= w_sel_size;
                r_addr       <= w_sel_addr;
                r_wdata      <= w_sel_wdata;
            end
        end
    end

    // Byte enables and lane-replicated write data from the latched command
    always_comb begin
        w_be        = 4'b0000;
        w_wdata_rep = r_wdata;
        case (r_size)
            c_SIZE_WORD: w_be = 4'b1111;
            c_SIZE_HALF: begin
                w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {r_wdata[15:0], r_wdata[15:0]};
            end
            c_SIZE_BYTE: begin
                w_be        = 4'b0001 << r_addr[1:0];
                w_wdata_rep = {4{r_wdata[7:0]}};
            end
            default: w_be = 4'b0000;
        endcase
    end

    // Lane extraction and sign extension of the RAM read word
    always_comb begin
        w_half_lane = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_addr[1:0])
            2'd0:    w_byte_lane = mem_rdata[7:0];
            2'd1:    w_byte_lane = mem_rdata[15:8];
            2'd2:    w_byte_lane = mem_rdata[23:16];
            default: w_byte_lane = mem_rdata[31:24];
        endcase
        case (r_size)
            c_SIZE_WORD: w_load_data = mem_rdata;
            c_SIZE_HALF: w_load_data = {{16{w_half_lane[15]}}, w_half_lane};
            c_SIZE_BYTE: w_load_data = {{24{w_byte_lane[7]}}, w_byte_lane};
            default:     w_load_data = 32'd0;
        endcase
    end

    // Next-state logic and per-state RAM / response outputs
    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_be      = 4'b0000;
        mem_wdata   = 32'd0;
        w_rvalid    = 1'b0;
        w_err       = 1'b0;
        w_rdata     = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_sel_aligned ? ST_ISSUE : ST_ERR;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_RESP;
                mem_en      = 1'b1;
                mem_we      = r_we;
                mem_addr    = r_addr[ADDR_W-1:2];
                mem_be      = w_be;
                mem_wdata   = w_wdata_rep;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                w_rvalid    = 1'b1;
                w_rdata     = r_we ? 32'd0 : w_load_data;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_rvalid    = 1'b1;
                w_err       = 1'b1;
            end
        endcase
        // A reset cycle drops the transaction: nothing reaches RAM or requester
        if (rst) begin
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_be    = 4'b0000;
            mem_wdata = 32'd0;
            w_rvalid  = 1'b0;
            w_err     = 1'b0;
            w_rdata   = 32'd0;
        end
    end

    // Route the response to the owning requester only
    assign m0_rvalid = w_rvalid && !r_owner;
    assign m1_rvalid = w_rvalid &&  r_owner;
    assign m0_err    = w_err    && !r_owner;
    assign m1_err    = w_err    &&  r_owner;
    assign m0_rdata  = (w_rvalid && !r_owner) ? w_rdata : 32'd0;
    assign m1_rdata  = (w_rvalid &&  r_owner) ? w_rdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_port_arbiter
// Description : Self-checking bench for dm_port_arbiter. A byte-addressed
//               reference memory predicts load data, byte enables and write
//               lanes; a word RAM responder sits on the DUT memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_port_arbiter;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [1:0]        m0_size, m1_size;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [31:0]       m0_wdata, m1_wdata;
    logic              m0_ready, m0_rvalid, m0_err, m1_ready, m1_rvalid, m1_err;
    logic [31:0]       m0_rdata, m1_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'd0;

    // Outputs of the fixed-priority instance
    logic              f_m0_ready, f_m0_rvalid, f_m0_err, f_m1_ready, f_m1_rvalid, f_m1_err;
    logic [31:0]       f_m0_rdata, f_m1_rdata;
    logic              f_mem_en, f_mem_we;
    logic [ADDR_W-3:0] f_mem_addr;
    logic [3:0]        f_mem_be;
    logic [31:0]       f_mem_wdata;

    logic [31:0]       ram [0:(1<<(ADDR_W-2))-1] = '{default: 32'd0};
    logic [7:0]        ref_mem [0:(1<<ADDR_W)-1];
    logic              ref_last;

    int                n_tests = 0;
    int                n_fail  = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.ADDR_W(ADDR_W), .FAIR(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dm_port_arbiter #(.ADDR_W(ADDR_W), .FAIR(1'b0)) u_fix (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(f_m0_ready), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(f_m1_ready), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
        .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_be(f_mem_be),
        .mem_wdata(f_mem_wdata), .mem_rdata(mem_rdata)
    );

    // Word RAM with byte enables and one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int l = 0; l < 4; l++) begin
                    if (mem_be[l]) ram[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
                end
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit p, input bit req, input bit we, input logic [1:0] sz,
                         input logic [ADDR_W-1:0] a, input logic [31:0] wd);
        if (p) begin
            m1_req = req; m1_we = we; m1_size = sz; m1_addr = a; m1_wdata = wd;
        end else begin
            m0_req = req; m0_we = we; m0_size = sz; m0_addr = a; m0_wdata = wd;
        end
    endtask

    // Waits (bounded) until the given port is granted; leaves the bench
    // #1 after the negedge of the grant cycle.
    task automatic wait_ready(input bit p);
        int waited = 0;
        while (!(p ? m1_ready : m0_ready) && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        chk(p ? "m1_ready" : "m0_ready", {31'd0, p ? m1_ready : m0_ready}, 32'd1);
    endtask

    // One complete transaction on port p, checked against the reference memory
    task automatic do_txn(input bit p, input bit we, input logic [1:0] sz,
                          input logic [ADDR_W-1:0] a, input logic [31:0] wd);
        bit          ok;
        int          nb, sh, tmp;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_rd;
        ok = (sz == 2'd0 && a[1:0] == 2'b00) || (sz == 2'd1 && !a[0]) || (sz == 2'd2);
        nb = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
        tmp = ((1 << nb) - 1) << a[1:0];
        exp_be = tmp[3:0];
        for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = wd[8*(l % nb) +: 8];
        exp_rd = 32'd0;
        for (int k = 0; k < nb; k++) exp_rd[8*k +: 8] = ref_mem[int'(a) + k];
        sh = 32 - 8 * nb;
        exp_rd = $signed(exp_rd << sh) >>> sh;

        @(negedge clk);
        drive(p, 1'b1, we, sz, a, wd);
        #1;
        wait_ready(p);
        ref_last = p;
        @(negedge clk);
        drive(p, 1'b0, we, sz, a, wd);
        #1;
        if (ok) begin
            chk("issue_mem_en", {31'd0, mem_en}, 32'd1);
            chk("issue_mem_we", {31'd0, mem_we}, {31'd0, we});
            chk("issue_mem_addr", {20'd0, mem_addr}, {20'd0, a[ADDR_W-1:2]});
            chk("issue_mem_be", {28'd0, mem_be}, {28'd0, exp_be});
            if (we) chk("issue_mem_wdata", mem_wdata, exp_wd);
            chk("issue_no_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
            if (we) for (int k = 0; k < nb; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
            @(negedge clk); #1;
            chk("resp_mem_en", {31'd0, mem_en}, 32'd0);
            chk("resp_rvalid", {30'd0, m1_rvalid, m0_rvalid}, p ? 32'd2 : 32'd1);
            chk("resp_err", {30'd0, m1_err, m0_err}, 32'd0);
            chk("resp_rdata", p ? m1_rdata : m0_rdata, we ? 32'd0 : exp_rd);
        end else begin
            chk("err_mem_en", {31'd0, mem_en}, 32'd0);
            chk("err_rvalid", {30'd0, m1_rvalid, m0_rvalid}, p ? 32'd2 : 32'd1);
            chk("err_flag", {30'd0, m1_err, m0_err}, p ? 32'd2 : 32'd1);
            chk("err_rdata", p ? m1_rdata : m0_rdata, 32'd0);
        end
        @(negedge clk); #1;
        chk("rvalid_pulse_end", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g_exp;
        for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = 8'd0;
        drive(1'b0, 1'b1, 1'b0, 2'd0, '0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 2'd0, '0, 32'd0);

        // Reset held two cycles with both requests pending
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        chk("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("rst_err", {30'd0, m1_err, m0_err}, 32'd0);
        chk("rst_mem", {30'd0, mem_we, mem_en}, 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_tie_m0", {30'd0, m1_ready, m0_ready}, 32'd1);
        ref_last = 1'b0;
        @(negedge clk);
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) @(negedge clk);

        // Directed accesses
        do_txn(1'b1, 1'b1, 2'd0, 14'h0000, 32'h80112233);
        do_txn(1'b0, 1'b1, 2'd0, 14'h0010, 32'hDEADBEEF);
        do_txn(1'b0, 1'b0, 2'd0, 14'h0010, 32'h0);
        do_txn(1'b1, 1'b1, 2'd1, 14'h0006, 32'h1234ABCD);
        do_txn(1'b1, 1'b0, 2'd1, 14'h0006, 32'h0);
        do_txn(1'b0, 1'b0, 2'd2, 14'h0003, 32'h0);
        do_txn(1'b0, 1'b0, 2'd2, 14'h0002, 32'h0);
        do_txn(1'b0, 1'b0, 2'd1, 14'h0001, 32'h0);
        do_txn(1'b1, 1'b1, 2'd3, 14'h0008, 32'h55555555);
        do_txn(1'b1, 1'b0, 2'd0, 14'h0008, 32'h0);

        // Reset in the middle of an issued load
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 14'h0010, 32'h0);
        #1;
        wait_ready(1'b0);
        @(negedge clk);
        rst = 1'b1;
        m0_req = 1'b0;
        #1;
        chk("rst_issue_mem_en", {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ref_last = 1'b1;
        #1;
        chk("rst_issue_no_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        m0_req = 1'b1;
        #1;
        chk("rst_issue_fresh_ready", {31'd0, m0_ready}, 32'd1);
        m0_req = 1'b0;
        @(negedge clk); #1;
        chk("rst_issue_idle", {31'd0, mem_en}, 32'd0);

        // Fairness: both requests held for four grants, after a reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_last = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 2'd0, 14'h0010, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 14'h0020, 32'h0);
        for (int i = 0; i < 4; i++) begin
            int waited = 0;
            #1;
            while (!(m0_ready || m1_ready) && waited < 20) begin
                @(negedge clk); #1;
                waited++;
            end
            g_exp = ~ref_last;
            chk("fair_grant", {30'd0, m1_ready, m0_ready}, g_exp ? 32'd2 : 32'd1);
            chk("fixed_grant", {30'd0, f_m1_ready, f_m0_ready}, 32'd1);
            ref_last = g_exp;
            @(negedge clk);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) @(negedge clk);

        // Randomized single-requester traffic against the reference memory
        for (int i = 0; i < 40; i++) begin
            logic [ADDR_W-1:0] ra;
            ra = ADDR_W'($urandom_range(0, 63));
            do_txn(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), ra, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
